// File: rtl/sched_pkg.sv
// Shared scheduler types and constants: FSM states, user/OS address split, OS entry vector.
package sched_pkg;

  typedef enum logic [2:0] {
    ST_OS,
    ST_SELECT,
    ST_DISPATCH,
    ST_RUN,
    ST_PREEMPT
  } sched_state_e;

  localparam logic [31:0] SO_LIMIT = 32'd616;
  localparam logic [31:0] OS_ENTRY = 32'd0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of ready after start, wrapping, start itself last.
module rr_pick #(
  parameter int unsigned NPROC = 4,
  parameter int unsigned PID_W = 2
) (
  input  logic [NPROC-1:0] ready,
  input  logic [PID_W-1:0] start,
  output logic             found,
  output logic [PID_W-1:0] pid
);

  logic [PID_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    pid   = start;
    idx   = '0;
    for (int unsigned i = 1; i <= NPROC; i++) begin
      // PID_W-bit addition wraps modulo NPROC, so i == NPROC lands back on start.
      idx = start + PID_W'(i);
      if (!found && ready[idx]) begin
        found = 1'b1;
        pid   = idx;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Round-robin process scheduler with quantum preemption; drives the PC jump path via valid/ack.
module quantum_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NPROC = 4,
  parameter int unsigned PID_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             qtm_load,
  input  logic [31:0]      qtm,
  input  logic [31:0]      pc_current,
  input  logic             instr_retire,
  input  logic             os_dispatch,
  input  logic [NPROC-1:0] ready_set,
  input  logic [NPROC-1:0] ready_clr,
  input  logic             pc_wr_en,
  input  logic [PID_W-1:0] pc_wr_pid,
  input  logic [31:0]      pc_wr_data,
  input  logic             jump_ack,
  output logic             jump_valid,
  output logic [31:0]      jump_target,
  output logic [PID_W-1:0] cur_pid,
  output logic             no_ready,
  output logic [31:0]      q_count
);

  sched_state_e     state_q, state_d;
  logic [31:0]      q_count_q, q_count_d;
  logic [31:0]      q_limit_q, q_limit_d;
  logic [NPROC-1:0] ready_q, ready_d;
  logic [31:0]      table_q [NPROC];
  logic [31:0]      table_d [NPROC];
  logic [PID_W-1:0] cur_pid_q, cur_pid_d;
  logic             jump_valid_q, jump_valid_d;
  logic [31:0]      jump_target_q, jump_target_d;
  logic             no_ready_q, no_ready_d;

  logic             pick_found;
  logic [PID_W-1:0] pick_pid;
  logic [31:0]      q_inc;

  rr_pick #(
    .NPROC(NPROC),
    .PID_W(PID_W)
  ) u_rr_pick (
    .ready(ready_q),
    .start(cur_pid_q),
    .found(pick_found),
    .pid  (pick_pid)
  );

  assign q_inc = (q_count_q == '1) ? q_count_q : q_count_q + 32'd1;

  always_comb begin
    state_d    = state_q;
    q_count_d  = q_count_q;
    q_limit_d  = qtm_load ? qtm : q_limit_q;
    ready_d    = (ready_q | ready_set) & ~ready_clr;
    table_d    = table_q;
    cur_pid_d  = cur_pid_q;
    no_ready_d = 1'b0;

    if (pc_wr_en) table_d[pc_wr_pid] = pc_wr_data;

    unique case (state_q)
      ST_OS: begin
        q_count_d = '0;
        if (os_dispatch) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (pick_found) begin
          cur_pid_d = pick_pid;
          state_d   = ST_DISPATCH;
        end else begin
          no_ready_d = 1'b1;
          state_d    = ST_OS;
        end
      end
      ST_DISPATCH: begin
        if (jump_ack) begin
          q_count_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (instr_retire) begin
          if (pc_current >= SO_LIMIT) begin
            // The preemption save is applied after the table write port, so it wins.
            if (q_limit_q != '0 && q_inc >= q_limit_q) begin
              table_d[cur_pid_q] = pc_current;
              q_count_d          = '0;
              state_d            = ST_PREEMPT;
            end else begin
              q_count_d = q_inc;
            end
          end else begin
            q_count_d = '0;
            state_d   = ST_OS;
          end
        end
      end
      ST_PREEMPT: begin
        if (jump_ack) state_d = ST_OS;
      end
      default: state_d = ST_OS;
    endcase

    jump_valid_d = (state_d == ST_DISPATCH) || (state_d == ST_PREEMPT);
    // Target is captured on entry to a jump state and frozen until the ack.
    if (jump_valid_q && state_d == state_q)
      jump_target_d = jump_target_q;
    else if (state_d == ST_DISPATCH)
      jump_target_d = table_d[cur_pid_d];
    else
      jump_target_d = OS_ENTRY;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_OS;
      q_count_q     <= '0;
      q_limit_q     <= '0;
      ready_q       <= '0;
      for (int unsigned i = 0; i < NPROC; i++) table_q[i] <= '0;
      cur_pid_q     <= PID_W'(NPROC - 1);
      jump_valid_q  <= 1'b0;
      jump_target_q <= '0;
      no_ready_q    <= 1'b0;
    end else if (!halt) begin
      state_q       <= state_d;
      q_count_q     <= q_count_d;
      q_limit_q     <= q_limit_d;
      ready_q       <= ready_d;
      table_q       <= table_d;
      cur_pid_q     <= cur_pid_d;
      jump_valid_q  <= jump_valid_d;
      jump_target_q <= jump_target_d;
      no_ready_q    <= no_ready_d;
    end
  end

  assign jump_valid  = jump_valid_q;
  assign jump_target = jump_target_q;
  assign cur_pid     = cur_pid_q;
  assign no_ready    = no_ready_q;
  assign q_count     = q_count_q;

endmodule
